// File: rtl/unidad_es.sv
// unidad_es: I/O port unit for the single-cycle processor.
// Buffers CPU writes in an output FIFO with a valid/ready interface and
// latches external input bytes behind per-port valid/ready handshakes.
// When an access cannot complete this cycle it raises stall so the CPU
// repeats the instruction.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   we_es, re_es          - CPU write/read of an I/O port this cycle
//   port_sel, wdata       - port number and write byte from the datapath
//   rdata, stall          - read byte to write-back mux, access not done
//   in_data/valid/rdy     - four external input ports (byte i at [8i+7:8i])
//   out_data/port/valid   - output FIFO head
//   out_ready             - external consumer accepts the head
module unidad_es #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_es,
    input  logic        re_es,
    input  logic [1:0]  port_sel,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        stall,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_valid,
    output logic [3:0]  in_rdy,
    output logic [7:0]  out_data,
    output logic [1:0]  out_port,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 2;
    localparam int unsigned NP = 4;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [PW-1:0] port;
        logic [DW-1:0] data;
    } entry_t;

    logic [NP-1:0][DW-1:0] hold;
    logic [NP-1:0]         full;
    logic [NP-1:0]         capture;

    entry_t                mem [DEPTH];
    entry_t                head;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  rd_ok;

    // Fullness uses the registered count, so a same-cycle pop never frees a slot
    assign fifo_full = (count == CW'(DEPTH));
    assign push      = we_es & ~reset & ~fifo_full;
    assign pop       = out_valid & out_ready;

    // A write takes priority; a read alongside it is ignored
    assign rd_ok     = re_es & ~we_es & ~reset & full[port_sel];

    assign in_rdy    = reset ? '0 : ~full;
    assign capture   = in_valid & in_rdy;

    // CPU-facing combinational response
    always_comb begin
        stall = 1'b0;
        rdata = '0;
        if (!reset) begin
            if (we_es) begin
                stall = fifo_full;
            end else if (re_es) begin
                stall = ~full[port_sel];
            end
        end
        if (rd_ok) begin
            rdata = hold[port_sel];
        end
    end

    // Input holding registers; capture and CPU read of one port are exclusive
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
            full <= '0;
        end else begin
            for (int i = 0; i < int'(NP); i++) begin
                if (capture[i]) begin
                    hold[i] <= in_data[8*i +: 8];
                    full[i] <= 1'b1;
                end else if (rd_ok && (port_sel == PW'(i))) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // FIFO storage; contents are masked by count, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{port: port_sel, data: wdata};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head presentation, zeroed while empty
    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head.data : '0;
    assign out_port  = out_valid ? head.port : '0;

endmodule

// File: tb/tb_unidad_es.sv
// Self-checking bench for unidad_es: directed steps with a scoreboard queue
// modelling the output FIFO.
module tb_unidad_es;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_es;
    logic        re_es;
    logic [1:0]  port_sel;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        stall;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_rdy;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic        out_valid;
    logic        out_ready;

    int          checks = 0;
    int          failures = 0;
    logic [9:0]  sb[$];
    int          mdl_cnt = 0;

    always #5 clk = ~clk;

    unidad_es #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .we_es     (we_es),
        .re_es     (re_es),
        .port_sel  (port_sel),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares the FIFO head and write stall against the model, then clocks once
    task automatic cyc();
        bit         do_push;
        bit         do_pop;
        logic [9:0] hd;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (!reset) begin
            chk("out_valid", 32'(out_valid), 32'(mdl_cnt != 0));
            if (mdl_cnt != 0) begin
                hd = sb[0];
                chk("out_data", 32'(out_data), 32'(hd[7:0]));
                chk("out_port", 32'(out_port), 32'(hd[9:8]));
                do_pop = out_ready;
            end else begin
                chk("out_data_empty", 32'(out_data), 32'(0));
            end
            if (we_es) begin
                chk("wr_stall", 32'(stall), 32'(mdl_cnt == DEPTH));
                do_push = (mdl_cnt < DEPTH);
            end
        end
        @(posedge clk);
        if (reset) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back({port_sel, wdata});
        end
        mdl_cnt = sb.size();
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && mdl_cnt != 0; i++) begin
            #1;
            cyc();
        end
        #1;
        chk("drained", 32'(out_valid), 32'(0));
    endtask

    initial begin
        reset     = 1'b1;
        we_es     = 1'b1;
        re_es     = 1'b0;
        port_sel  = 2'd0;
        wdata     = 8'hEE;
        in_data   = 32'hDEADBEEF;
        in_valid  = 4'hF;
        out_ready = 1'b0;

        // Reset held two cycles with activity on every input
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_stall", 32'(stall), 32'(0));
            chk("rst_in_rdy", 32'(in_rdy), 32'(0));
            chk("rst_rdata", 32'(rdata), 32'(0));
            cyc();
        end
        reset    = 1'b0;
        we_es    = 1'b0;
        in_valid = 4'h0;
        #1;
        chk("post_rst_in_rdy", 32'(in_rdy), 32'hF);
        chk("post_rst_stall", 32'(stall), 32'(0));
        chk("post_rst_rdata", 32'(rdata), 32'(0));
        cyc();

        // Input handshake on port 2
        in_valid          = 4'b0100;
        in_data[23:16]    = 8'hA5;
        #1;
        chk("p2_rdy_before", 32'(in_rdy[2]), 32'(1));
        cyc();
        in_valid = 4'h0;
        re_es    = 1'b1;
        port_sel = 2'd2;
        #1;
        chk("p2_in_rdy_full", 32'(in_rdy), 32'b1011);
        chk("p2_rdata", 32'(rdata), 32'hA5);
        chk("p2_stall", 32'(stall), 32'(0));
        cyc();
        re_es = 1'b0;
        #1;
        chk("p2_in_rdy_after", 32'(in_rdy), 32'hF);
        cyc();

        // Read stall on empty port 1, released by a capture one cycle later
        re_es    = 1'b1;
        port_sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("p1_stall_wait", 32'(stall), 32'(1));
            chk("p1_rdata_wait", 32'(rdata), 32'(0));
            cyc();
        end
        in_valid       = 4'b0010;
        in_data[15:8]  = 8'h3C;
        #1;
        chk("p1_no_bypass_stall", 32'(stall), 32'(1));
        chk("p1_no_bypass_rdata", 32'(rdata), 32'(0));
        cyc();
        in_valid = 4'h0;
        #1;
        chk("p1_stall_done", 32'(stall), 32'(0));
        chk("p1_rdata", 32'(rdata), 32'h3C);
        cyc();
        re_es = 1'b0;

        // FIFO fill to full with consumer stalled, then release
        out_ready = 1'b0;
        we_es     = 1'b1;
        port_sel  = 2'd3;
        for (int k = 1; k <= 5; k++) begin
            wdata = 8'(k);
            #1;
            cyc();
        end
        #1;
        chk("fifo_full_stall", 32'(stall), 32'(1));
        out_ready = 1'b1;
        cyc();
        #1;
        chk("fifo_slot_freed", 32'(stall), 32'(0));
        cyc();
        we_es = 1'b0;
        drain();

        // Back-to-back writes with continuous pops; pointers wrap twice
        out_ready = 1'b1;
        we_es     = 1'b1;
        port_sel  = 2'd1;
        for (int k = 0; k < 10; k++) begin
            wdata = 8'h10 + 8'(k);
            #1;
            chk("stream_stall", 32'(stall), 32'(0));
            cyc();
        end
        we_es = 1'b0;
        drain();

        // Read and write together: write wins, held byte survives
        out_ready     = 1'b0;
        in_valid      = 4'b0001;
        in_data[7:0]  = 8'h77;
        #1;
        cyc();
        in_valid = 4'h0;
        we_es    = 1'b1;
        re_es    = 1'b1;
        port_sel = 2'd0;
        wdata    = 8'h88;
        #1;
        chk("coll_rdata", 32'(rdata), 32'(0));
        chk("coll_stall", 32'(stall), 32'(0));
        cyc();
        we_es = 1'b0;
        re_es = 1'b0;
        #1;
        chk("coll_full0_kept", 32'(in_rdy[0]), 32'(0));
        cyc();
        re_es = 1'b1;
        #1;
        chk("coll_late_rdata", 32'(rdata), 32'h77);
        chk("coll_late_stall", 32'(stall), 32'(0));
        cyc();
        re_es     = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset mid-operation discards buffered input and output bytes
        out_ready      = 1'b0;
        we_es          = 1'b1;
        port_sel       = 2'd2;
        wdata          = 8'h5A;
        in_valid       = 4'b1000;
        in_data[31:24] = 8'hC3;
        #1;
        cyc();
        we_es    = 1'b0;
        in_valid = 4'h0;
        reset    = 1'b1;
        #1;
        cyc();
        reset = 1'b0;
        #1;
        chk("mid_rst_in_rdy", 32'(in_rdy), 32'hF);
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_out_data", 32'(out_data), 32'(0));
        re_es    = 1'b1;
        port_sel = 2'd3;
        #1;
        chk("mid_rst_read_stall", 32'(stall), 32'(1));
        re_es = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
